// File: rtl/axil_slave_regfile.sv
// AXI-Lite slave register file: NUM_REGS byte-strobed registers with independent read/write FSMs.
// Optional: define AXIL_SLV_DECERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_slave_regfile #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS       = 16,
    parameter int ADDR_LSB       = $clog2(AXI_DATA_WIDTH / 8),
    parameter int IDX_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic                               s_axil_awvalid,
    output logic                               s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]          s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]        s_axil_wstrb,
    input  logic                               s_axil_wvalid,
    output logic                               s_axil_wready,
    output logic [1:0]                         s_axil_bresp,
    output logic                               s_axil_bvalid,
    input  logic                               s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic                               s_axil_arvalid,
    output logic                               s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                         s_axil_rresp,
    output logic                               s_axil_rvalid,
    input  logic                               s_axil_rready,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                reg_wr_pulse
);

    localparam int          STRB_W    = AXI_DATA_WIDTH / 8;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef AXIL_SLV_DECERR_EN
    localparam logic [1:0]  RESP_BAD  = 2'b10;
`else
    localparam logic [1:0]  RESP_BAD  = 2'b00;
`endif

    typedef enum logic {W_COLLECT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    // The whole word address must be below NUM_REGS, not just the index bits.
    function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return (addr >> ADDR_LSB) < AXI_ADDR_WIDTH'(NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return IDX_W'(addr >> ADDR_LSB);
    endfunction

    wstate_t                   wstate;
    rstate_t                   rstate;
    logic                      aw_done;
    logic                      w_done;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         wstrb_q;
    logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

    logic             wr_commit;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;

    assign wr_commit   = (wstate == W_COLLECT) && aw_done && w_done;
    assign wr_in_range = addr_in_range(awaddr_q);
    assign wr_idx      = addr_idx(awaddr_q);
    assign rd_in_range = addr_in_range(s_axil_araddr);
    assign rd_idx      = addr_idx(s_axil_araddr);

    // Write channel: collect AW and W in any order, commit, then hold B until bready.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate         <= W_COLLECT;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
        end else begin
            case (wstate)
                W_COLLECT: begin
                    if (wr_commit) begin
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        s_axil_bvalid <= 1'b1;
                        s_axil_bresp  <= wr_in_range ? RESP_OKAY : RESP_BAD;
                        wstate        <= W_RESP;
                    end else begin
                        if (s_axil_awready && s_axil_awvalid) begin
                            awaddr_q       <= s_axil_awaddr;
                            aw_done        <= 1'b1;
                            s_axil_awready <= 1'b0;
                        end else if (!aw_done) begin
                            s_axil_awready <= 1'b1;
                        end
                        if (s_axil_wready && s_axil_wvalid) begin
                            wdata_q       <= s_axil_wdata;
                            wstrb_q       <= s_axil_wstrb;
                            w_done        <= 1'b1;
                            s_axil_wready <= 1'b0;
                        end else if (!w_done) begin
                            s_axil_wready <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        s_axil_bvalid  <= 1'b0;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                        wstate         <= W_COLLECT;
                    end
                end
                default: wstate <= W_COLLECT;
            endcase
        end
    end

    // Register bank and write pulse.
    // NOTE: these are software-visible control flops, not a RAM, so every entry is reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (wr_commit && wr_in_range) begin
                reg_wr_pulse[wr_idx] <= 1'b1;
                for (int k = 0; k < STRB_W; k++) begin
                    if (wstrb_q[k]) regs[wr_idx][k*8 +: 8] <= wdata_q[k*8 +: 8];
                end
            end
        end
    end

    // Read channel: sample the bank on the AR handshake, then hold R until rready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate         <= R_IDLE;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (s_axil_arready && s_axil_arvalid) begin
                        s_axil_rdata   <= rd_in_range ? regs[rd_idx] : '0;
                        s_axil_rresp   <= rd_in_range ? RESP_OKAY : RESP_BAD;
                        s_axil_rvalid  <= 1'b1;
                        s_axil_arready <= 1'b0;
                        rstate         <= R_DATA;
                    end else begin
                        s_axil_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid  <= 1'b0;
                        s_axil_arready <= 1'b1;
                        rstate         <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Self-checking bench for axil_slave_regfile: vector table of write/read pairs plus
// hand-written sequences for handshake timing, collisions, back-pressure and mid-transaction reset.
module tb_axil_slave_regfile;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;

`ifdef AXIL_SLV_DECERR_EN
    localparam logic [1:0] EXP_BAD = 2'b10;
`else
    localparam logic [1:0] EXP_BAD = 2'b00;
`endif

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [AW-1:0]   awaddr = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [AW-1:0]   araddr = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]    reg_wr_pulse;

    axil_slave_regfile #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [NR-1:0] pulse_seen;

    typedef struct {
        logic [AW-1:0]   wr_addr;
        logic [DW-1:0]   wr_data;
        logic [DW/8-1:0] wr_strb;
        logic [1:0]      exp_bresp;
        logic [NR-1:0]   exp_pulse;
        logic [AW-1:0]   rd_addr;
        logic [DW-1:0]   exp_rdata;
        logic [1:0]      exp_rresp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] get_reg(input int i);
        return reg_q[i*DW +: DW];
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
        pulse_seen |= reg_wr_pulse;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] s, output logic [1:0] resp);
        logic aw_hs, w_hs, got;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        resp = 2'bxx;
        for (int n = 0; n < 50 && (awvalid || wvalid); n++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
        end
        if (awvalid || wvalid) check("write_addr_data_timeout", 1'b0, 1'b1);
        awvalid = 1'b0; wvalid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            if (bvalid) begin
                resp = bresp;
                got  = 1'b1;
            end
            tick();
        end
        if (!got) check("write_resp_timeout", 1'b0, 1'b1);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
        logic done;
        araddr = a; arvalid = 1'b1;
        d = 'x; resp = 2'bxx;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            done = arready;
            tick();
        end
        arvalid = 1'b0;
        if (!done) check("read_addr_timeout", 1'b0, 1'b1);
        rready = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            if (rvalid) begin
                d = rdata;
                resp = rresp;
                done = 1'b1;
            end
            tick();
        end
        rready = 1'b0;
        if (!done) check("read_data_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]      resp;
        logic [DW-1:0]   d;
        logic [NR*DW-1:0] snap;
        int              bcnt;

        vecs[0] = '{32'h00, 32'h12345678, 4'hF, 2'b00,  16'h0001, 32'h00, 32'h12345678, 2'b00};
        vecs[1] = '{32'h03, 32'hAABBCCDD, 4'h2, 2'b00,  16'h0001, 32'h02, 32'h1234CC78, 2'b00};
        vecs[2] = '{32'h3C, 32'hCAFEF00D, 4'hC, 2'b00,  16'h8000, 32'h3C, 32'hCAFE0000, 2'b00};
        vecs[3] = '{32'h3C, 32'h11111111, 4'h0, 2'b00,  16'h8000, 32'h3F, 32'hCAFE0000, 2'b00};
        vecs[4] = '{32'h80, 32'hFFFFFFFF, 4'hF, EXP_BAD, 16'h0000, 32'h3C, 32'hCAFE0000, 2'b00};
        vecs[5] = '{32'h04, 32'h9876ABCD, 4'h3, 2'b00,  16'h0002, 32'h04, 32'h0000ABCD, 2'b00};

        pulse_seen = '0;

        // Reset state
        aresetn = 1'b0;
        tick(); tick();
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_reg_q_zero", reg_q == '0, 1'b1);
        check("rst_pulse", reg_wr_pulse, 16'h0);
        check("rst_rdata", rdata, 32'h0);
        aresetn = 1'b1;
        tick();
        check("ready_aw_after_rst", awready, 1'b1);
        check("ready_w_after_rst", wready, 1'b1);
        check("ready_ar_after_rst", arready, 1'b1);

        // Same-cycle AW+W to register 2 with bready held high
        awaddr = 32'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_bvalid_not_yet", bvalid, 1'b0);
        check("t1_awready_low", awready, 1'b0);
        tick();
        check("t1_bvalid", bvalid, 1'b1);
        check("t1_bresp", bresp, 2'b00);
        check("t1_reg2", get_reg(2), 32'hDEADBEEF);
        check("t1_pulse", reg_wr_pulse, 16'h0004);
        tick();
        check("t1_bvalid_done", bvalid, 1'b0);
        check("t1_pulse_one_cycle", reg_wr_pulse, 16'h0000);
        check("t1_awready_back", awready, 1'b1);

        // W one cycle before AW, partial strobes over 0xFFFFFFFF
        axi_write(32'h0C, 32'hFFFFFFFF, 4'hF, resp);
        check("t2_prefill_reg3", get_reg(3), 32'hFFFFFFFF);
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        awaddr = 32'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bvalid) bcnt++;
        end
        check("t2_one_bresp", bcnt, 1);
        check("t2_reg3", get_reg(3), 32'hFF22FF44);

        // Read register 2 with rready held low for 3 cycles
        araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_rvalid_held", rvalid, 1'b1);
            check("t3_rdata_stable", rdata, 32'hDEADBEEF);
            check("t3_arready_low", arready, 1'b0);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("t3_rvalid_cleared", rvalid, 1'b0);
        check("t3_arready_back", arready, 1'b1);

        // AR handshake in the same cycle as the write commit to register 5
        axi_write(32'h14, 32'h1, 4'hF, resp);
        awaddr = 32'h14; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h14; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("t4_rvalid", rvalid, 1'b1);
        check("t4_rdata_old", rdata, 32'h1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        axi_read(32'h14, d, resp);
        check("t4_rdata_new", d, 32'h2);

        // Out-of-range write and read
        snap = reg_q;
        pulse_seen = '0;
        axi_write(32'h40, 32'hAAAAAAAA, 4'hF, resp);
        check("t5_oor_bresp", resp, EXP_BAD);
        check("t5_oor_regs_unchanged", reg_q == snap, 1'b1);
        check("t5_oor_no_pulse", pulse_seen, 16'h0);
        axi_read(32'h44, d, resp);
        check("t5_oor_rdata", d, 32'h0);
        check("t5_oor_rresp", resp, EXP_BAD);

        // Reset while a write response is pending
        bready = 1'b0;
        awaddr = 32'h20; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("t6_bvalid_pending", bvalid, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        check("t6_bvalid_dropped", bvalid, 1'b0);
        check("t6_reg_q_cleared", reg_q == '0, 1'b1);
        check("t6_awready_in_rst", awready, 1'b0);
        tick();
        aresetn = 1'b1;
        tick();
        axi_write(32'h20, 32'h77, 4'hF, resp);
        check("t6_post_rst_bresp", resp, 2'b00);
        check("t6_post_rst_reg8", get_reg(8), 32'h77);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            pulse_seen = '0;
            axi_write(vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wr_strb, resp);
            check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_bresp);
            check($sformatf("vec%0d_pulse", i), pulse_seen, vecs[i].exp_pulse);
            axi_read(vecs[i].rd_addr, d, resp);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_rresp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
